// File: rtl/div_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_unit_pkg
// Description : Shared definitions for the iterative MIPS DIV/DIVU divider:
//               ALU control codes, divider state encoding, iteration count.
// Revision    : 1.0 - initial release
// ============================================================================
package div_unit_pkg;

    // ALU control codes for the divide instructions, alongside the ALU codes
    localparam logic [3:0] DIV_CONTROL  = 4'b1000;
    localparam logic [3:0] DIVU_CONTROL = 4'b1001;

    // One restoring iteration per quotient bit
    localparam int DIV_CYCLES = 32;

    // Divider sequencing states
    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

endpackage : div_unit_pkg
`default_nettype wire

// File: rtl/div_unit_step.sv
`default_nettype none
// ============================================================================
// Module      : div_unit_step
// Description : One radix-2 restoring division iteration. Shifts {rem,quo}
//               left by one, trial-subtracts the divisor and keeps the
//               difference when it does not borrow.
// Revision    : 1.0 - initial release
// ============================================================================
module div_unit_step #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] i_rem,
    input  logic [DATA_W-1:0] i_quo,
    input  logic [DATA_W-1:0] i_div,
    output logic [DATA_W-1:0] o_rem,
    output logic [DATA_W-1:0] o_quo
);

    // The partial remainder is always below the divisor, so the shifted value
    // fits in DATA_W+1 bits and a non-borrowing difference fits in DATA_W.
    logic [DATA_W:0] w_shifted;
    logic [DATA_W:0] w_diff;

    assign w_shifted = {i_rem, i_quo[DATA_W-1]};
    assign w_diff    = w_shifted - {1'b0, i_div};

    // Restore on borrow, otherwise accept the difference and set the quotient bit
    always_comb begin
        if (w_diff[DATA_W]) begin
            o_rem = w_shifted[DATA_W-1:0];
            o_quo = {i_quo[DATA_W-2:0], 1'b0};
        end else begin
            o_rem = w_diff[DATA_W-1:0];
            o_quo = {i_quo[DATA_W-2:0], 1'b1};
        end
    end

endmodule : div_unit_step
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module      : div_unit
// Description : Iterative radix-2 restoring divider for MIPS DIV/DIVU.
//               Produces quotient (lo_out) and remainder (hi_out), stalls the
//               pipeline while iterating, supports annul and defines a
//               divide-by-zero result (lo=all ones, hi=dividend).
// Revision    : 1.0 - initial release
// ============================================================================
module div_unit
    import div_unit_pkg::*;
#(
    parameter int DATA_W = DIV_CYCLES
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              is_signed,
    input  logic              annul,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] hi_out,
    output logic [DATA_W-1:0] lo_out,
    output logic              done,
    output logic              stall
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DATA_W - 1);

    div_state_t        r_state;
    div_state_t        w_state_nxt;
    logic [CNT_W-1:0]  r_count;
    logic [DATA_W-1:0] r_rem;
    logic [DATA_W-1:0] r_quo;
    logic [DATA_W-1:0] r_div;
    logic              r_qneg;
    logic              r_rneg;

    logic [DATA_W-1:0] w_a_mag;
    logic [DATA_W-1:0] w_b_mag;
    logic [DATA_W-1:0] w_rem_nxt;
    logic [DATA_W-1:0] w_quo_nxt;
    logic              w_accept;
    logic              w_b_zero;
    logic              w_last;

    // Magnitudes only for signed operation; DIVU uses the raw operands
    assign w_a_mag  = (is_signed && a[DATA_W-1]) ? (~a + 1'b1) : a;
    assign w_b_mag  = (is_signed && b[DATA_W-1]) ? (~b + 1'b1) : b;
    assign w_b_zero = (b == '0);
    assign w_accept = (r_state == DIV_IDLE) && start && !annul;
    assign w_last   = (r_count == C_LAST);

    div_unit_step #(
        .DATA_W (DATA_W)
    ) u_step (
        .i_rem (r_rem),
        .i_quo (r_quo),
        .i_div (r_div),
        .o_rem (w_rem_nxt),
        .o_quo (w_quo_nxt)
    );

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= DIV_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, done pulse and stall request; annul and reset override all
    always_comb begin
        w_state_nxt = r_state;
        done        = 1'b0;
        stall       = 1'b0;
        case (r_state)
            DIV_IDLE: begin
                stall = start;
                if (start) begin
                    w_state_nxt = w_b_zero ? DIV_DONE : DIV_BUSY;
                end
            end
            DIV_BUSY: begin
                stall = 1'b1;
                if (w_last) begin
                    w_state_nxt = DIV_DONE;
                end
            end
            DIV_DONE: begin
                done        = 1'b1;
                w_state_nxt = DIV_IDLE;
            end
            default: begin
                w_state_nxt = DIV_IDLE;
            end
        endcase
        if (annul) begin
            w_state_nxt = DIV_IDLE;
            done        = 1'b0;
            stall       = 1'b0;
        end
        if (!resetn) begin
            stall = 1'b0;
        end
    end

    // Operand capture, iteration and result write-back with sign correction
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_count <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_div   <= '0;
            r_qneg  <= 1'b0;
            r_rneg  <= 1'b0;
            hi_out  <= '0;
            lo_out  <= '0;
        end else begin
            if (w_accept) begin
                r_count <= '0;
                r_rem   <= '0;
                r_quo   <= w_a_mag;
                r_div   <= w_b_mag;
                r_qneg  <= is_signed & (a[DATA_W-1] ^ b[DATA_W-1]);
                r_rneg  <= is_signed & a[DATA_W-1];
                if (w_b_zero) begin
                    lo_out <= '1;
                    hi_out <= a;
                end
            end else if ((r_state == DIV_BUSY) && !annul) begin
                r_count <= r_count + 1'b1;
                r_rem   <= w_rem_nxt;
                r_quo   <= w_quo_nxt;
                if (w_last) begin
                    lo_out <= r_qneg ? (~w_quo_nxt + 1'b1) : w_quo_nxt;
                    hi_out <= r_rneg ? (~w_rem_nxt + 1'b1) : w_rem_nxt;
                end
            end
        end
    end

endmodule : div_unit
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_unit
// Description : Directed self-checking bench for div_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_unit;

    logic        clk;
    logic        resetn;
    logic        start;
    logic        is_signed;
    logic        annul;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        done;
    logic        stall;

    int n_chk = 0;
    int n_err = 0;

    div_unit #(
        .DATA_W (32)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .is_signed (is_signed),
        .annul     (annul),
        .a         (a),
        .b         (b),
        .hi_out    (hi_out),
        .lo_out    (lo_out),
        .done      (done),
        .stall     (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge (start of next cycle)
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one operation in the current cycle (cycle 0) and follow it to done
    task automatic run_div(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                           input logic sgn, input logic [31:0] elo, input logic [31:0] ehi,
                           input int ecyc);
        a         = ta;
        b         = tb;
        is_signed = sgn;
        start     = 1'b1;
        #1;
        for (int c = 0; c <= ecyc; c++) begin
            chk({tag, "_done"},  32'(done),  32'(c == ecyc));
            chk({tag, "_stall"}, 32'(stall), 32'(c < ecyc));
            if (c == ecyc) begin
                chk({tag, "_lo"}, lo_out, elo);
                chk({tag, "_hi"}, hi_out, ehi);
                start = 1'b0;
            end
            tick();
        end
    endtask

    initial begin
        resetn    = 1'b0;
        start     = 1'b0;
        is_signed = 1'b0;
        annul     = 1'b0;
        a         = '0;
        b         = '0;
        tick();
        tick();
        chk("rst_hi",    hi_out,      32'h0);
        chk("rst_lo",    lo_out,      32'h0);
        chk("rst_done",  32'(done),   32'h0);
        chk("rst_stall", 32'(stall),  32'h0);
        resetn = 1'b1;
        tick();

        // Basic unsigned, signed sign rules, signed overflow, divide by zero
        run_div("divu_100_7",  32'd100,        32'd7,          1'b0, 32'd14,       32'd2,        33);
        run_div("div_m7_2",    32'hFFFFFFF9,   32'd2,          1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 33);
        run_div("div_7_m2",    32'd7,          32'hFFFFFFFE,   1'b1, 32'hFFFFFFFD, 32'd1,        33);
        run_div("div_ovf",     32'h80000000,   32'hFFFFFFFF,   1'b1, 32'h80000000, 32'h0,        33);
        run_div("divu_5_0",    32'd5,          32'd0,          1'b0, 32'hFFFFFFFF, 32'd5,        1);
        chk("divz_stall_after", 32'(stall), 32'h0);

        // Annul in cycle 10, then a fresh operation accepted in cycle 11
        a         = 32'd100;
        b         = 32'd7;
        is_signed = 1'b0;
        start     = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            chk("annul_run_stall", 32'(stall), 32'h1);
            chk("annul_run_done",  32'(done),  32'h0);
            tick();
        end
        annul = 1'b1;
        #1;
        chk("annul_stall", 32'(stall), 32'h0);
        chk("annul_done",  32'(done),  32'h0);
        tick();
        annul = 1'b0;
        chk("annul_keep_lo", lo_out, 32'hFFFFFFFF);
        chk("annul_keep_hi", hi_out, 32'd5);
        run_div("annul_restart", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 33);

        // Asynchronous reset in the middle of cycle 5 of an operation
        a         = 32'd100;
        b         = 32'd7;
        is_signed = 1'b0;
        start     = 1'b1;
        for (int c = 0; c < 5; c++) tick();
        #2;
        resetn = 1'b0;
        #1;
        chk("midrst_hi",    hi_out,     32'h0);
        chk("midrst_lo",    lo_out,     32'h0);
        chk("midrst_done",  32'(done),  32'h0);
        chk("midrst_stall", 32'(stall), 32'h0);
        start = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
        run_div("divu_max_1", 32'hFFFFFFFF, 32'd1, 1'b0, 32'hFFFFFFFF, 32'h0, 33);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_div_unit
`default_nettype wire
